// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the two requester ports and the memory-side bus of
//   mem_port_arbiter.
//   Port 0 is MEM-stage load/store. Port 1 is instruction fetch and is read-only.
//
//   Signals
//     req0/we0/addr0/wdata0   port 0 request, write flag, byte address, store data
//     gnt0/done0/rdata0/err0  port 0 grant pulse, completion pulse, load data, fault
//     req1/addr1              port 1 fetch request and byte address
//     gnt1/done1/rdata1/err1  port 1 grant, completion, fetched word, fault
//     mem_read/mem_write      strobes to the Memory instance
//     mem_addr/mem_wd/mem_rd  Memory address, write data and read data
//     busy                    arbiter is not idle
//
//   Modports
//     master  requesters plus the memory model (the environment side)
//     slave   the arbiter itself
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        done0;
  logic [31:0] rdata0;
  logic        err0;

  logic        req1;
  logic [31:0] addr1;
  logic        gnt1;
  logic        done1;
  logic [31:0] rdata1;
  logic        err1;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        busy;

  modport master (
    output req0, we0, addr0, wdata0, req1, addr1, mem_rd,
    input  gnt0, done0, rdata0, err0, gnt1, done1, rdata1, err1,
           mem_read, mem_write, mem_addr, mem_wd, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, addr1, mem_rd,
    output gnt0, done0, rdata0, err0, gnt1, done1, rdata1, err1,
           mem_read, mem_write, mem_addr, mem_wd, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one byte-addressed data memory between two requesters.
//   Port 0 is load/store and port 1 is instruction fetch.
//   Only one word access is in flight at a time.
//
//   The FSM runs IDLE -> ACCESS -> DONE -> IDLE.
//   A misaligned or out-of-range address skips ACCESS and goes straight to
//   DONE with err set.
//
//   Timing
//     A grant is combinational in the IDLE cycle (cycle 0).
//     The memory is driven for MEM_LAT cycles.
//     The done pulse comes in cycle MEM_LAT+1, or in cycle 1 for a fault.
//
//   Ports
//     clk, rst_n   clock and asynchronous active-low reset
//     bus          mem_port_arbiter_if.slave (requesters and memory bus)
//
//   Parameters
//     MEM_LAT      cycles the memory interface is held per access (>= 1)
//     MEM_BYTES    memory size in bytes, used for the bounds check
//
//   Build option
//     ARB_RR_EN    when defined, the arbiter is round-robin: if both ports
//                  request, the port not granted last wins.
//                  When undefined, port 0 has fixed priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [31:0]     ADDR_MAX = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t           state;
  logic             cur_id;    // port being served: 0 or 1
  logic             cur_we;
  logic [CNT_W-1:0] lat_cnt;   // remaining ACCESS cycles after this one

  logic             prefer0;
  logic             win0;
  logic             win1;
  logic             sel_we;
  logic             sel_fault;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;

`ifdef ARB_RR_EN
  logic last_id;               // port granted most recently
  assign prefer0 = last_id;    // port 1 went last, so it is port 0's turn
`else
  assign prefer0 = 1'b1;
`endif

  // Grants are Mealy outputs in IDLE.
  // They are gated by rst_n so that nothing is granted while reset is held.
  assign win0     = (state == S_IDLE) && rst_n && bus.req0 && (!bus.req1 || prefer0);
  assign win1     = (state == S_IDLE) && rst_n && bus.req1 && !win0;
  assign bus.gnt0 = win0;
  assign bus.gnt1 = win1;

  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
    sel_addr  = bus.addr1;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (win0) begin
      sel_addr  = bus.addr0;
      sel_we    = bus.we0;
      sel_wdata = bus.wdata0;
    end
  end

  assign sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_MAX);

  // NOTE: state and registered outputs use non-blocking assignments, so every
  // right-hand side sees the pre-edge value no matter how statements are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_id        <= 1'b0;
      cur_we        <= 1'b0;
      lat_cnt       <= '0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wd    <= '0;
      bus.busy      <= 1'b0;
`ifdef ARB_RR_EN
      last_id       <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (win0 || win1) begin
            cur_id       <= win1;
            cur_we       <= sel_we;
            bus.mem_addr <= sel_addr;
            bus.mem_wd   <= sel_wdata;
            bus.busy     <= 1'b1;
`ifdef ARB_RR_EN
            last_id      <= win1;
`endif
            if (sel_fault) begin
              state     <= S_DONE;
              bus.done0 <= win0;
              bus.done1 <= win1;
              bus.err0  <= win0;
              bus.err1  <= win1;
            end else begin
              state         <= S_ACCESS;
              lat_cnt       <= LAT_LOAD;
              bus.mem_read  <= !sel_we;
              // With a single-cycle access, the first ACCESS cycle is also the write cycle.
              bus.mem_write <= sel_we && (MEM_LAT == 1);
            end
          end
        end

        S_ACCESS: begin
          if (lat_cnt == '0) begin
            state         <= S_DONE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.done0     <= !cur_id;
            bus.done1     <= cur_id;
            if (!cur_we) begin
              if (cur_id) bus.rdata1 <= bus.mem_rd;
              else        bus.rdata0 <= bus.mem_rd;
            end
          end else begin
            lat_cnt       <= lat_cnt - 1'b1;
            // Assert write only for the last ACCESS cycle, so there is exactly one write edge.
            bus.mem_write <= cur_we && (lat_cnt == CNT_W'(1));
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.err0  <= 1'b0;
          bus.err1  <= 1'b0;
          bus.busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with MEM_LAT=2 and a 1 KiB
//   little-endian byte memory.
//   Expected values come from a transaction-level model: a byte array,
//   the last data read per port, and the port granted last.
//   Define ARB_RR_EN on the command line to build the round-robin variant.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int MEM_LAT   = 2;
  localparam int MEM_BYTES = 1024;
`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Physical memory driven by the DUT.
  logic [7:0] mem [0:MEM_BYTES-1];
  logic [9:0] ra0, ra1, ra2, ra3;
  assign ra0 = bus.mem_addr[9:0];
  assign ra1 = ra0 + 10'd1;
  assign ra2 = ra0 + 10'd2;
  assign ra3 = ra0 + 10'd3;
  assign bus.mem_rd = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[ra0] <= bus.mem_wd[7:0];
      mem[ra1] <= bus.mem_wd[15:8];
      mem[ra2] <= bus.mem_wd[23:16];
      mem[ra3] <= bus.mem_wd[31:24];
    end
  end

  // Reference model state.
  logic [7:0]  model_mem [0:MEM_BYTES-1];
  logic [31:0] model_rdata [2];
  int          model_last;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_word(input logic [31:0] a);
    int b = int'(a % MEM_BYTES);
    return {mem[(b+3)%MEM_BYTES], mem[(b+2)%MEM_BYTES], mem[(b+1)%MEM_BYTES], mem[b]};
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b = int'(a % MEM_BYTES);
    return {model_mem[(b+3)%MEM_BYTES], model_mem[(b+2)%MEM_BYTES],
            model_mem[(b+1)%MEM_BYTES], model_mem[b]};
  endfunction

  function automatic bit model_fault(input logic [31:0] a);
    longint unsigned la = longint'(a);
    return (la % 4 != 0) || (la + 4 > MEM_BYTES);
  endfunction

  function automatic int model_winner(input bit r0, input bit r1);
    if (r0 && r1) return (RR_MODE && model_last == 0) ? 1 : 0;
    return r0 ? 0 : 1;
  endfunction

  task automatic model_commit(input int id, input bit we, input logic [31:0] a, input logic [31:0] wd);
    model_last = id;
    if (!model_fault(a)) begin
      if (we) begin
        for (int k = 0; k < 4; k++) model_mem[int'(a) + k] = wd[8*k +: 8];
      end else begin
        model_rdata[id] = model_word(a);
      end
    end
  endtask

  task automatic model_reset();
    model_last     = 1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  task automatic poke(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      mem[a + k]       = w[8*k +: 8];
      model_mem[a + k] = w[8*k +: 8];
    end
  endtask

  // Serve one grant.
  // Entry: just after a falling edge, DUT idle, requests driven.
  // Exit:  one cycle after done, DUT idle again.
  task automatic serve_one(input int id, input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input bit exp_err, input logic [31:0] exp_rdata, input string tag);
    int rd_cnt = 0;
    int wr_cnt = 0;
    int lat    = 0;
    bit both   = 0;
    bit stray  = 0;
    check({tag, " gnt0"}, bus.gnt0, id == 0);
    check({tag, " gnt1"}, bus.gnt1, id == 1);
    @(posedge clk); #1;
    if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    for (int k = 1; k <= 4 * MEM_LAT + 8; k++) begin
      @(negedge clk); #1;
      rd_cnt += int'(bus.mem_read);
      wr_cnt += int'(bus.mem_write);
      if (bus.mem_read && bus.mem_write) both = 1;
      if (id == 0 ? bus.done1 : bus.done0) stray = 1;
      if (id == 0 ? bus.done0 : bus.done1) begin
        lat = k;
        break;
      end
    end
    check({tag, " done latency"}, lat, exp_err ? 1 : MEM_LAT + 1);
    check({tag, " err"}, id == 0 ? bus.err0 : bus.err1, exp_err);
    check({tag, " rdata"}, id == 0 ? bus.rdata0 : bus.rdata1, exp_rdata);
    check({tag, " mem_read cycles"}, rd_cnt, (!exp_err && !we) ? MEM_LAT : 0);
    check({tag, " mem_write cycles"}, wr_cnt, (!exp_err && we) ? 1 : 0);
    check({tag, " read+write overlap / other done"}, {both, stray}, 2'b00);
    if (we && !exp_err) check({tag, " memory word"}, act_word(a), wd);
    @(negedge clk); #1;
    check({tag, " idle flags"}, {bus.busy, bus.done0, bus.done1, bus.err0, bus.err1}, 5'b0);
  endtask

  task automatic serve_model(input string tag);
    int          id = model_winner(bus.req0, bus.req1);
    logic [31:0] a  = (id == 0) ? bus.addr0 : bus.addr1;
    bit          we = (id == 0) ? bus.we0 : 1'b0;
    logic [31:0] wd = (id == 0) ? bus.wdata0 : 32'h0;
    bit          f  = model_fault(a);
    model_commit(id, we, a, wd);
    serve_one(id, we, a, wd, f, model_rdata[id], tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flags"}, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                            bus.mem_read, bus.mem_write, bus.busy}, 9'b0);
    check({tag, " data"}, bus.rdata0 | bus.rdata1 | bus.mem_addr | bus.mem_wd, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(9, 0);
    logic [31:0] a = {20'h0, 8'($urandom_range(255, 0)), 2'b00};
    if (k == 7) a = a | 32'($urandom_range(3, 1));
    else if (k == 8) a = 32'h400;
    else if (k == 9) a = 32'h3FC;
    return a;
  endfunction

  typedef struct {
    bit          req0;
    bit          we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    bit          req1;
    logic [31:0] addr1;
    int          exp_id;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wid;
    bit          wwe;
    logic [31:0] wa;
    logic [31:0] wwd;
    int          got;
    int          exp;
    bit          bad;

    vecs[0] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h10,  1, 1'b0, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h20,  32'hDEAD_BEEF, 1'b1, 32'h20,  0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h22,  32'h0,        1'b0, 32'h0,   0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h3FE, 32'h0,        1'b0, 32'h0,   0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h0,   0, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h400, 1, 1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 1'b1, 32'h3FC, 32'h0BAD_F00D, 1'b0, 32'h0,   0, 1'b0, 32'hCAFE_F00D};
    vecs[7] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h3FC, 1, 1'b0, 32'h0BAD_F00D};
    vecs[8] = '{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h11,  1, 1'b1, 32'h0BAD_F00D};
    vecs[9] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0,   0, 1'b0, 32'h1234_5678};

    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]       = 8'h00;
      model_mem[i] = 8'h00;
    end
    poke(32'h10,  32'h1234_5678);
    poke(32'h3FC, 32'hCAFE_F00D);
    model_reset();

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b1; bus.addr1 = 32'h10;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held with a request pending: every output stays 0.
    @(negedge clk); @(negedge clk); #1;
    check_all_zero("reset held");

    // Release reset, start a fetch, then abort it mid-ACCESS.
    @(negedge clk); rst_n = 1'b1; #1;
    check("abort fetch gnt1", bus.gnt1, 1'b1);
    @(posedge clk); #1; bus.req1 = 1'b0;
    @(negedge clk); #1;
    check("abort fetch mem_read in ACCESS", bus.mem_read, 1'b1);
    rst_n = 1'b0; #1;
    check_all_zero("mid-fetch reset");
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (bus.done0 || bus.done1 || bus.busy) bad = 1;
    end
    check("no done after fetch abort", bad, 1'b0);
    model_reset();

    // Directed vectors; each row's leftover request is then served using the model.
    for (int i = 0; i < 10; i++) begin
      bus.req0 = vecs[i].req0; bus.we0 = vecs[i].we0;
      bus.addr0 = vecs[i].addr0; bus.wdata0 = vecs[i].wdata0;
      bus.req1 = vecs[i].req1; bus.addr1 = vecs[i].addr1;
      #1;
      wid = vecs[i].exp_id;
      wwe = (wid == 0) ? vecs[i].we0 : 1'b0;
      wa  = (wid == 0) ? vecs[i].addr0 : vecs[i].addr1;
      wwd = (wid == 0) ? vecs[i].wdata0 : 32'h0;
      model_commit(wid, wwe, wa, wwd);
      serve_one(wid, wwe, wa, wwd, vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      while (bus.req0 || bus.req1) serve_model($sformatf("vec%0d drain", i));
    end

    // Store aborted by reset during its first ACCESS cycle: memory unchanged, no done.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h40; bus.wdata0 = 32'h55AA_55AA;
    #1;
    check("abort store gnt0", bus.gnt0, 1'b1);
    @(posedge clk); #1; bus.req0 = 1'b0;
    @(negedge clk); #1;
    check("abort store no early write", bus.mem_write, 1'b0);
    rst_n = 1'b0; #1;
    check_all_zero("mid-store reset");
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (bus.done0 || bus.mem_write) bad = 1;
    end
    check("no done/write after store abort", bad, 1'b0);
    check("memory unchanged after abort", act_word(32'h40), model_word(32'h40));
    model_reset();

    // Both ports hold their requests for six consecutive grants.
    bus.we0 = 1'b0; bus.addr0 = 32'h10; bus.addr1 = 32'h20;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    got = 0;
    for (int c = 0; c < 6 * (MEM_LAT + 2) + 10 && got < 6; c++) begin
      #1;
      if (bus.gnt0 || bus.gnt1) begin
        exp = model_winner(1'b1, 1'b1);
        check($sformatf("held grant %0d port", got), bus.gnt1 ? 1 : 0, exp);
        model_commit(exp, 1'b0, exp == 0 ? 32'h10 : 32'h20, 32'h0);
        got++;
      end
      if (got == 6) begin
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("held grant count", got, 6);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (!bus.busy) break;
    end
    check("held run idle", bus.busy, 1'b0);
    check("held run rdata0", bus.rdata0, model_rdata[0]);
    check("held run rdata1", bus.rdata1, model_rdata[1]);

    // Randomized traffic checked against the model.
    for (int it = 0; it < 40; it++) begin
      int unsigned r = $urandom_range(2, 0);
      bus.req0   = (r != 1);
      bus.req1   = (r != 0);
      bus.we0    = 1'($urandom_range(1, 0));
      bus.addr0  = rand_addr();
      bus.wdata0 = $urandom();
      bus.addr1  = rand_addr();
      #1;
      while (bus.req0 || bus.req1) serve_model($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
